// File: rtl/rotary_enc_pkg.sv
// Shared types and register map for the rotary encoder slot core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rotary_enc_pkg;

  // Quadrature decoder states; the comment gives the {A,B} code each state sits on.
  typedef enum logic [2:0] {
    Q_IDLE = 3'd0,  // 11
    Q_CW1  = 3'd1,  // 01
    Q_CW2  = 3'd2,  // 00
    Q_CW3  = 3'd3,  // 10
    Q_CCW1 = 3'd4,  // 10
    Q_CCW2 = 3'd5,  // 00
    Q_CCW3 = 3'd6   // 01
  } quad_state_t;

  // {A,B} encoder codes
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_10 = 2'b10;

  // Register word addresses (addr[1:0])
  localparam logic [1:0] REG_POS   = 2'd0;
  localparam logic [1:0] REG_STAT  = 2'd1;
  localparam logic [1:0] REG_CTRL  = 2'd2;
  localparam logic [1:0] REG_LIMIT = 2'd3;

  // CTRL bit indices
  localparam int CTRL_EN        = 0;
  localparam int CTRL_WRAP      = 1;
  localparam int CTRL_CLR_POS   = 2;
  localparam int CTRL_CLR_FLAGS = 3;

  // STAT bit indices
  localparam int STAT_SW   = 0;
  localparam int STAT_PEND = 1;
  localparam int STAT_DIR  = 2;
  localparam int STAT_HIT  = 3;

endpackage

// File: rtl/rotary_debounce.sv
// Two-flop synchroniser followed by a stability counter for one encoder input.
// Latency: 2 sync cycles + DB_CYCLES stable cycles before dout follows din.
// Backpressure: none; free-running level filter.
// Ports: clk, reset_n (async active-low), din (raw pin), dout (debounced level).
module rotary_debounce #(
  parameter int   DB_CYCLES = 100_000,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles where the synchronised input disagrees with the
  // current debounced level; any agreeing cycle (a glitch ending) restarts it.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      db_q    <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/rotary_enc_ctrl_core.sv
// Rotary encoder slot core: debounce A/B/SW, quadrature-decode detents, bounded position.
// Latency: position updates the cycle after the decoder's step pulse; reads are combinational.
// Backpressure: none; register slot is always ready for reads and writes.
// Ports: clk, reset_n (async active-low); slot bus cs/read/write/addr[4:0]/wr_data[31:0]
//        -> rd_data[31:0]; encoder pins enc_a, enc_b (idle high), enc_sw (1 = pressed).
module rotary_enc_ctrl_core
  import rotary_enc_pkg::*;
#(
  parameter int DB_CYCLES = 100_000,
  parameter int POS_W     = 16,
  parameter int DEF_LIMIT = 99
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enc_sw
);

  logic a_db, b_db, sw_db;
  logic [1:0] ab;

  rotary_debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_db_a (
    .clk(clk), .reset_n(reset_n), .din(enc_a), .dout(a_db));
  rotary_debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_db_b (
    .clk(clk), .reset_n(reset_n), .din(enc_b), .dout(b_db));
  rotary_debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db_sw (
    .clk(clk), .reset_n(reset_n), .din(enc_sw), .dout(sw_db));

  assign ab = {a_db, b_db};

  // Reads have no side effects, so the read strobe is not needed.
  logic bus_unused;
  assign bus_unused = ^{read, wr_data[31:POS_W]};

  // ---------------- slot write decode ----------------
  logic             wr_sel, ctrl_wr, lim_wr, clr_pos, clr_flags;
  logic [POS_W-1:0] new_lim;

  assign wr_sel    = cs && write && (addr[4:2] == 3'b000);
  assign ctrl_wr   = wr_sel && (addr[1:0] == REG_CTRL);
  assign lim_wr    = wr_sel && (addr[1:0] == REG_LIMIT);
  assign clr_pos   = ctrl_wr && wr_data[CTRL_CLR_POS];
  assign clr_flags = ctrl_wr && wr_data[CTRL_CLR_FLAGS];
  assign new_lim   = wr_data[POS_W-1:0];

  // ---------------- registers ----------------
  quad_state_t      state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] lim_q;
  logic             en_q, wrap_q;
  logic             pend_q, pend_d;
  logic             dir_q, dir_d;
  logic             hit_q, hit_d;
  logic             sw_prev_q;
  logic             step_cw, step_ccw;

  // ---------------- quadrature decoder ----------------
  // A reverse code backtracks one state; a two-bit jump is ignored; code 11
  // always returns to IDLE, emitting a step only when it completes a cycle.
  always_comb begin
    state_d  = state_q;
    step_cw  = 1'b0;
    step_ccw = 1'b0;
    if (!en_q) begin
      state_d = Q_IDLE;
    end else begin
      case (state_q)
        Q_IDLE: begin
          if (ab == AB_01)      state_d = Q_CW1;
          else if (ab == AB_10) state_d = Q_CCW1;
        end
        Q_CW1: begin
          if (ab == AB_00)      state_d = Q_CW2;
          else if (ab == AB_11) state_d = Q_IDLE;
        end
        Q_CW2: begin
          if (ab == AB_10)      state_d = Q_CW3;
          else if (ab == AB_01) state_d = Q_CW1;
          else if (ab == AB_11) state_d = Q_IDLE;
        end
        Q_CW3: begin
          if (ab == AB_11) begin
            state_d = Q_IDLE;
            step_cw = 1'b1;
          end else if (ab == AB_00) begin
            state_d = Q_CW2;
          end
        end
        Q_CCW1: begin
          if (ab == AB_00)      state_d = Q_CCW2;
          else if (ab == AB_11) state_d = Q_IDLE;
        end
        Q_CCW2: begin
          if (ab == AB_01)      state_d = Q_CCW3;
          else if (ab == AB_10) state_d = Q_CCW1;
          else if (ab == AB_11) state_d = Q_IDLE;
        end
        Q_CCW3: begin
          if (ab == AB_11) begin
            state_d  = Q_IDLE;
            step_ccw = 1'b1;
          end else if (ab == AB_00) begin
            state_d = Q_CCW2;
          end
        end
        default: state_d = Q_IDLE;
      endcase
    end
  end

  // ---------------- position and flags ----------------
  // A LIMIT write landing with a step uses the new limit so POS never exceeds it.
  logic [POS_W-1:0] lim_eff;
  logic             hit_set;

  assign lim_eff = lim_wr ? new_lim : lim_q;

  always_comb begin
    pos_d   = pos_q;
    dir_d   = dir_q;
    hit_set = 1'b0;
    if (step_cw || step_ccw) dir_d = step_cw;
    if (clr_pos) begin
      pos_d = '0;
    end else if (lim_wr && (new_lim < pos_q)) begin
      pos_d = new_lim;
    end else if (step_cw) begin
      if (pos_q < lim_eff) begin
        pos_d = pos_q + 1'b1;
      end else begin
        hit_set = 1'b1;
        if (wrap_q) pos_d = '0;
      end
    end else if (step_ccw) begin
      if (pos_q != '0) begin
        pos_d = pos_q - 1'b1;
      end else begin
        hit_set = 1'b1;
        if (wrap_q) pos_d = lim_eff;
      end
    end
  end

  // Set events beat a simultaneous clear.
  assign hit_d  = (hit_q && !clr_flags) || hit_set;
  assign pend_d = (pend_q && !clr_flags) || (sw_db && !sw_prev_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= Q_IDLE;
      pos_q     <= '0;
      lim_q     <= POS_W'(DEF_LIMIT);
      en_q      <= 1'b1;
      wrap_q    <= 1'b0;
      pend_q    <= 1'b0;
      dir_q     <= 1'b0;
      hit_q     <= 1'b0;
      sw_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      pend_q    <= pend_d;
      dir_q     <= dir_d;
      hit_q     <= hit_d;
      sw_prev_q <= sw_db;
      if (ctrl_wr) begin
        en_q   <= wr_data[CTRL_EN];
        wrap_q <= wr_data[CTRL_WRAP];
      end
      if (lim_wr) lim_q <= new_lim;
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    rd_data = '0;
    if (addr[4:2] == 3'b000) begin
      case (addr[1:0])
        REG_POS:   rd_data[POS_W-1:0] = pos_q;
        REG_STAT: begin
          rd_data[STAT_SW]   = sw_db;
          rd_data[STAT_PEND] = pend_q;
          rd_data[STAT_DIR]  = dir_q;
          rd_data[STAT_HIT]  = hit_q;
        end
        REG_CTRL: begin
          rd_data[CTRL_EN]   = en_q;
          rd_data[CTRL_WRAP] = wrap_q;
        end
        REG_LIMIT: rd_data[POS_W-1:0] = lim_q;
        default:   rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rotary_enc_ctrl_core.sv
module tb_rotary_enc_ctrl_core;

  localparam int HOLD = 12;  // cycles each encoder level is held

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic        enc_a, enc_b, enc_sw;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rotary_enc_ctrl_core #(.DB_CYCLES(4), .POS_W(16), .DEF_LIMIT(99)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw));

  // ---------------- reference model ----------------
  // Detent tracking: map codes onto a 4-phase wheel; net progress of +4 phases
  // ending on 11 is a CW detent, -4 a CCW detent; arriving at 11 any other way
  // discards the partial progress.
  int         m_pos, m_lim, m_off;
  bit         m_en, m_wrap, m_dir, m_hit, m_pend, m_sw;
  logic [1:0] m_code;

  function automatic int phase_of(input logic [1:0] c);
    case (c)
      2'b11:   return 0;
      2'b01:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] code_of(input int ph);
    logic [1:0] tbl [4];
    tbl[0] = 2'b11; tbl[1] = 2'b01; tbl[2] = 2'b00; tbl[3] = 2'b10;
    return tbl[ph & 3];
  endfunction

  function automatic void m_reset();
    m_pos = 0; m_lim = 99; m_off = 0;
    m_en = 1; m_wrap = 0; m_dir = 0; m_hit = 0; m_pend = 0; m_sw = 0;
    m_code = 2'b11;
  endfunction

  function automatic void m_step(input bit cw);
    m_dir = cw;
    if (cw) begin
      if (m_pos < m_lim) m_pos = m_pos + 1;
      else begin m_hit = 1; if (m_wrap) m_pos = 0; end
    end else begin
      if (m_pos > 0) m_pos = m_pos - 1;
      else begin m_hit = 1; if (m_wrap) m_pos = m_lim; end
    end
  endfunction

  function automatic void m_code_seen(input logic [1:0] c);
    int d;
    if (!m_en) begin
      m_off = 0;
    end else begin
      d = (phase_of(c) - phase_of(m_code)) & 3;
      if (d == 1) m_off = m_off + 1;
      else if (d == 3) m_off = m_off - 1;
      if (c == 2'b11) begin
        if (m_off == 4) m_step(1'b1);
        else if (m_off == -4) m_step(1'b0);
        m_off = 0;
      end
    end
    m_code = c;
  endfunction

  function automatic void m_write(input logic [4:0] a, input logic [31:0] d);
    if (a[4:2] != 3'b000) return;
    if (a[1:0] == 2'd2) begin
      m_en = d[0]; m_wrap = d[1];
      if (d[2]) m_pos = 0;
      if (d[3]) begin m_pend = 0; m_hit = 0; end
    end else if (a[1:0] == 2'd3) begin
      m_lim = int'(d[15:0]);
      if (m_lim < m_pos) m_pos = m_lim;
    end
  endfunction

  // ---------------- bus / pin drivers ----------------
  task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; wr_data = '0;
    m_write(a, d);
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; addr = a;
    #1 d = rd_data;
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic drive_code(input logic [1:0] c);
    @(negedge clk);
    enc_a = c[1]; enc_b = c[0];
    repeat (HOLD) @(negedge clk);
    m_code_seen(c);
  endtask

  task automatic drive_sw(input logic v);
    @(negedge clk);
    enc_sw = v;
    repeat (HOLD) @(negedge clk);
    if (v && !m_sw) m_pend = 1;
    m_sw = v;
  endtask

  task automatic cw_cycle();
    drive_code(2'b01); drive_code(2'b00); drive_code(2'b10); drive_code(2'b11);
  endtask

  task automatic ccw_cycle();
    drive_code(2'b10); drive_code(2'b00); drive_code(2'b01); drive_code(2'b11);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_reset();
  endtask

  function automatic logic [31:0] m_stat();
    return {28'd0, m_hit, m_dir, m_pend, m_sw};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    apply_reset();
    reg_read(5'd0, d);
    checks++; if (d !== 32'd0)  begin errors++; $display("FAIL reset_pos got=%0d want=0", d); end
    reg_read(5'd1, d);
    checks++; if (d !== 32'd0)  begin errors++; $display("FAIL reset_stat got=%h want=0", d); end
    reg_read(5'd2, d);
    checks++; if (d !== 32'd1)  begin errors++; $display("FAIL reset_ctrl got=%h want=1", d); end
    reg_read(5'd3, d);
    checks++; if (d !== 32'd99) begin errors++; $display("FAIL reset_limit got=%0d want=99", d); end
  endtask

  task automatic test_rotation();
    logic [31:0] p, s;
    repeat (3) cw_cycle();
    reg_read(5'd0, p); reg_read(5'd1, s);
    checks++; if (p !== 32'd3 || p !== 32'(m_pos)) begin errors++; $display("FAIL cw3_pos got=%0d want=3 model=%0d", p, m_pos); end
    checks++; if (s[2] !== 1'b1) begin errors++; $display("FAIL cw3_dir got=%b want=1", s[2]); end
    ccw_cycle();
    reg_read(5'd0, p); reg_read(5'd1, s);
    checks++; if (p !== 32'd2 || p !== 32'(m_pos)) begin errors++; $display("FAIL ccw1_pos got=%0d want=2 model=%0d", p, m_pos); end
    checks++; if (s[2] !== 1'b0) begin errors++; $display("FAIL ccw1_dir got=%b want=0", s[2]); end
  endtask

  task automatic test_glitch();
    logic [31:0] p;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); enc_a = 1'b0;
      @(negedge clk); enc_a = 1'b1;
      repeat (19) @(negedge clk);
    end
    reg_read(5'd0, p);
    checks++; if (p !== 32'(m_pos)) begin errors++; $display("FAIL glitch_pos got=%0d want=%0d", p, m_pos); end
    // decoder must still be at rest: one clean CW detent adds exactly one
    cw_cycle();
    reg_read(5'd0, p);
    checks++; if (p !== 32'(m_pos)) begin errors++; $display("FAIL glitch_then_cw got=%0d want=%0d", p, m_pos); end
  endtask

  task automatic test_partial();
    logic [31:0] p, p0;
    reg_read(5'd0, p0);
    drive_code(2'b01); drive_code(2'b00); drive_code(2'b01); drive_code(2'b11);
    reg_read(5'd0, p);
    checks++; if (p !== p0 || p !== 32'(m_pos)) begin errors++; $display("FAIL backtrack_pos got=%0d want=%0d", p, p0); end
    drive_code(2'b01); drive_code(2'b10); drive_code(2'b11);
    reg_read(5'd0, p);
    checks++; if (p !== p0 || p !== 32'(m_pos)) begin errors++; $display("FAIL jump_pos got=%0d want=%0d", p, p0); end
  endtask

  task automatic test_limits();
    logic [31:0] p, s;
    reg_write(5'd3, 32'd3);
    reg_write(5'd2, 32'h5);            // enable + clr_pos
    repeat (2) cw_cycle();
    reg_read(5'd0, p);
    checks++; if (p !== 32'd2) begin errors++; $display("FAIL lim_setup got=%0d want=2", p); end
    repeat (3) cw_cycle();
    reg_read(5'd0, p); reg_read(5'd1, s);
    checks++; if (p !== 32'd3 || p !== 32'(m_pos)) begin errors++; $display("FAIL sat_pos got=%0d want=3", p); end
    checks++; if (s[3] !== 1'b1) begin errors++; $display("FAIL sat_hit got=%b want=1", s[3]); end
    reg_write(5'd2, 32'h3);            // enable + wrap
    cw_cycle();
    reg_read(5'd0, p);
    checks++; if (p !== 32'd0 || p !== 32'(m_pos)) begin errors++; $display("FAIL wrap_cw got=%0d want=0", p); end
    ccw_cycle();
    reg_read(5'd0, p);
    checks++; if (p !== 32'd3 || p !== 32'(m_pos)) begin errors++; $display("FAIL wrap_ccw got=%0d want=3", p); end
    reg_write(5'd3, 32'd1);
    reg_read(5'd0, p);
    checks++; if (p !== 32'd1 || p !== 32'(m_pos)) begin errors++; $display("FAIL lim_clamp got=%0d want=1", p); end
    reg_read(5'd2, p);
    checks++; if (p !== 32'h3) begin errors++; $display("FAIL ctrl_readback got=%h want=3", p); end
  endtask

  task automatic test_switch();
    logic [31:0] s;
    drive_sw(1'b1);
    reg_read(5'd1, s);
    checks++; if (s[1:0] !== 2'b11 || s !== m_stat()) begin errors++; $display("FAIL sw_press got=%h want=%h", s, m_stat()); end
    drive_sw(1'b0);
    reg_read(5'd1, s);
    checks++; if (s[1:0] !== 2'b10 || s !== m_stat()) begin errors++; $display("FAIL sw_release got=%h want=%h", s, m_stat()); end
    reg_write(5'd2, 32'h9);            // enable + clr_flags
    reg_read(5'd1, s);
    checks++; if (s[1] !== 1'b0 || s !== m_stat()) begin errors++; $display("FAIL sw_clear got=%h want=%h", s, m_stat()); end
  endtask

  task automatic test_addr_alias();
    logic [31:0] d;
    reg_write(5'b00111, 32'd5);        // out-of-map write must be ignored
    reg_read(5'd3, d);
    checks++; if (d !== 32'(m_lim)) begin errors++; $display("FAIL alias_write got=%0d want=%0d", d, m_lim); end
    reg_read(5'b10000, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL alias_read got=%h want=0", d); end
  endtask

  task automatic test_enable();
    logic [31:0] p, p0;
    reg_write(5'd3, 32'd99);
    reg_read(5'd0, p0);
    reg_write(5'd2, 32'h0);
    cw_cycle();
    reg_read(5'd0, p);
    checks++; if (p !== p0 || p !== 32'(m_pos)) begin errors++; $display("FAIL disabled_pos got=%0d want=%0d", p, p0); end
    reg_write(5'd2, 32'h1);
    cw_cycle();
    reg_read(5'd0, p);
    checks++; if (p !== 32'(m_pos)) begin errors++; $display("FAIL reenabled_pos got=%0d want=%0d", p, m_pos); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p;
    drive_code(2'b01); drive_code(2'b00);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    enc_a = 1'b1; enc_b = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    reg_read(5'd0, p);
    checks++; if (p !== 32'd0) begin errors++; $display("FAIL midreset_pos got=%0d want=0", p); end
    reg_read(5'd3, p);
    checks++; if (p !== 32'd99) begin errors++; $display("FAIL midreset_limit got=%0d want=99", p); end
    cw_cycle();
    reg_read(5'd0, p);
    checks++; if (p !== 32'd1 || p !== 32'(m_pos)) begin errors++; $display("FAIL midreset_cw got=%0d want=1", p); end
  endtask

  task automatic test_random();
    logic [31:0] p, s;
    int ph;
    ph = phase_of(m_code);
    for (int r = 0; r < 3; r++) begin
      reg_write(5'd3, 32'($urandom_range(0, 6)));
      reg_write(5'd2, {28'd0, 2'b11, 1'($urandom_range(0, 1)), 1'b1});
      for (int k = 0; k < 30; k++) begin
        ph = ($urandom_range(0, 1) != 0) ? ph + 1 : ph + 3;
        drive_code(code_of(ph));
        reg_read(5'd0, p); reg_read(5'd1, s);
        checks++; if (p !== 32'(m_pos)) begin errors++; $display("FAIL rand_pos r=%0d k=%0d got=%0d want=%0d", r, k, p, m_pos); end
        checks++; if (s !== m_stat()) begin errors++; $display("FAIL rand_stat r=%0d k=%0d got=%h want=%h", r, k, s, m_stat()); end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; wr_data = '0;
    enc_a = 1'b1; enc_b = 1'b1; enc_sw = 1'b0;
    m_reset();
    test_reset();
    test_rotation();
    test_glitch();
    test_partial();
    test_limits();
    test_switch();
    test_addr_alias();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
